job_scheduler: RTL and testbench
================================

# job_scheduler

Round-robin scheduler that shares the single start/done/error processing engine (the `fsm_controller` unit) among `NREQ` requesters. It sits between the requester ports and the engine's `start`/`done`/`error` handshake. It issues one job at a time and supervises it with a timeout and bounded retry, then returns a per-requester success (`ack`) or failure (`nack`) pulse.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, maximum cycles spent in WAIT before a job is declared failed (≥2)
- `MAX_RETRY`, 2, re-issues allowed after a failure before `nack` (0..7)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `req`  in  NREQ  level request; held by requester until its `ack`/`nack`
- `eng_start`  out  1  one-cycle start pulse to engine
- `eng_done`  in  1  engine completion (sampled only in WAIT)
- `eng_error`  in  1  engine error (sampled only in WAIT)
- `grant`  out  NREQ  one-hot owner of engine, zero when idle
- `grant_id`  out  $clog2(NREQ)  binary index of current owner
- `ack`  out  NREQ  one-hot one-cycle success pulse
- `nack`  out  NREQ  one-hot one-cycle failure pulse
- `busy`  out  1  high in every state except IDLE
- `retry_cnt`  out  3  retries used by current job

## Operation
States: IDLE, ISSUE, WAIT, RETRY, ACK, NACK.

- **IDLE:**
  - If `req` is nonzero, pick the first set bit searching upward (wrapping) from `ptr+1`.
  - Latch the pick into `grant`/`grant_id` and clear `retry_cnt`, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:** `eng_start`=1 for exactly this cycle; timer cleared; go to WAIT.
- **WAIT:** timer increments each cycle.
  - `eng_done` and no `eng_error` → ACK.
  - `eng_error`, or timer==`TIMEOUT`-1 without done → failure.
  - If `eng_done` and `eng_error` are high in the same cycle, error wins.
- **Failure:**
  - If `retry_cnt` < `MAX_RETRY`: increment `retry_cnt` and go to RETRY.
  - Otherwise go to NACK.
- **RETRY:** one idle gap cycle with `eng_start`=0, then go to ISSUE. The same requester keeps the grant.
- **ACK / NACK:**
  - Pulse `ack[grant_id]` or `nack[grant_id]` for one cycle.
  - Set `ptr`=`grant_id`.
  - Go to IDLE; `grant` clears on entry to IDLE.
- **Requests:**
  - A requester dropping `req` mid-job is ignored; the job runs to ACK/NACK.
  - `req` from the owner is not re-sampled until IDLE.
  - Requester must drop `req` the cycle after its `ack`/`nack`. A request still high in IDLE is treated as a new job.
- **Engine inputs:** `eng_done`/`eng_error` outside WAIT are ignored (no latching).
- **`ptr` width:** `$clog2(NREQ)`; search arithmetic is modulo `NREQ`.

## Timing
- **Reset values:**
  - State IDLE, `ptr`=`NREQ`-1 (requester 0 has first priority).
  - `grant`, `grant_id`, `ack`, `nack`, `eng_start`, `busy`, `retry_cnt`, timer = 0.
- **Reset mid-job:** asserting `reset` low in any state returns to IDLE immediately. No `ack`/`nack` is emitted and `eng_start` drops asynchronously.
- **Request to start:** `req` sampled at edge t0 in IDLE → `grant`, `busy`, `eng_start` high in cycle t0+1.
- **Done to ack:** `eng_done` sampled at edge t1 in WAIT → `ack` high in cycle t1+1 → IDLE at t1+2.
- **Minimum job period:** 4 cycles (IDLE, ISSUE, WAIT×1, ACK).
- **Timeout:** fires after exactly `TIMEOUT` WAIT cycles.
- **Retry period:** each retry adds 2 cycles (RETRY, ISSUE) before WAIT.
- **Outputs:** all registered, none combinational from inputs. `grant` is stable from ISSUE through ACK/NACK.

## Structure
- Shared package `sched_pkg`:
  - State enum `sched_state_t`.
  - Default localparams `SCHED_TIMEOUT_DEF`, `SCHED_RETRY_DEF`.
  - Function `onehot_to_idx`.
- Sub-module `rr_pick`: purely combinational round-robin search. Inputs `req` and `ptr`; outputs one-hot `pick` plus `pick_id`, with `NREQ` parameter. Top level owns `ptr` and all state.
- Timer width is `$clog2(TIMEOUT)`.

## Test plan
- **Single job:** after reset, `req`=4'b0001, `eng_done` 3 cycles after `eng_start` → `eng_start` pulse at t0+1, `ack`=4'b0001 one cycle, `busy` low after.
- **Round robin:** `req`=4'b1011 held, each job completes → grant order 0,1,3,0,1,3; no requester granted twice while another waits.
- **Retry then success:** `eng_error` on first attempt, `eng_done` on second → `retry_cnt`=1, two `eng_start` pulses separated by the RETRY gap, `ack` issued, no `nack`.
- **Timeout exhaustion:** `TIMEOUT`=8, `MAX_RETRY`=2, engine silent → 3 `eng_start` pulses, each WAIT exactly 8 cycles, then `nack[id]` pulse, `retry_cnt`=2.
- **Simultaneous done+error:** both high in the same WAIT cycle → treated as failure (RETRY). Also, `eng_done` pulsed in IDLE → ignored, no `ack`.
- **Reset mid-WAIT:** `reset` low during WAIT → all outputs 0 immediately. After release, `req`=4'b0010 is granted to requester 1 (`ptr`=`NREQ`-1, so search from 0 finds bit 1).

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and defaults for the round-robin job scheduler.
package sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RETRY = 3'd3,
      S_ACK   = 3'd4,
      S_NACK  = 3'd5
   } sched_state_t;

   localparam int SCHED_TIMEOUT_DEF = 64;
   localparam int SCHED_RETRY_DEF   = 2;

   // Binary index of a one-hot vector of up to 8 requesters (zero if empty).
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/job_scheduler_if.sv
// Requester and engine signals of the job scheduler, bundled as one port.
//
// Handshakes:
//   requester: req[i] is a level held until ack[i] or nack[i] pulses for one
//              cycle; the requester drops req[i] the following cycle, and a
//              req still high once the scheduler is back in IDLE is a new job.
//   engine:    eng_start is a one-cycle pulse; the engine answers with
//              eng_done and/or eng_error, which only count while the
//              scheduler is waiting on the job (error wins over done).
interface job_scheduler_if #(
   parameter int NREQ = 4
);
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0] req;
   logic            eng_start;
   logic            eng_done;
   logic            eng_error;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   grant_id;
   logic [NREQ-1:0] ack;
   logic [NREQ-1:0] nack;
   logic            busy;
   logic [2:0]      retry_cnt;

   // Scheduler side.
   modport master (
      input  req, eng_done, eng_error,
      output eng_start, grant, grant_id, ack, nack, busy, retry_cnt
   );

   // Requesters plus engine side.
   modport slave (
      output req, eng_done, eng_error,
      input  eng_start, grant, grant_id, ack, nack, busy, retry_cnt
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit upward from ptr+1.
module rr_pick
   import sched_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic [PW-1:0]   pick_id
);

   logic          found;
   logic [PW-1:0] idx;
   logic [7:0]    pick8;
   logic [2:0]    id8;

   // Walk NREQ positions starting just after ptr, wrapping modulo NREQ.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      pick8             = '0;
      pick8[NREQ-1:0]   = pick;
      id8               = onehot_to_idx(pick8);
      pick_id           = id8[PW-1:0];
   end

endmodule

// File: rtl/job_scheduler.sv
// Round-robin scheduler sharing one start/done/error engine among NREQ
// requesters, with per-attempt timeout and bounded retry.
module job_scheduler
   import sched_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int TIMEOUT   = SCHED_TIMEOUT_DEF,
   parameter int MAX_RETRY = SCHED_RETRY_DEF
) (
   input  logic          clk,
   input  logic          reset,
   job_scheduler_if.master bus,
   output sched_state_t  state_o
);

   localparam int IW = $clog2(NREQ);
   localparam int TW = $clog2(TIMEOUT);

   sched_state_t    state_q;
   logic [IW-1:0]   ptr_q;
   logic [NREQ-1:0] grant_q;
   logic [IW-1:0]   grant_id_q;
   logic [NREQ-1:0] ack_q;
   logic [NREQ-1:0] nack_q;
   logic            start_q;
   logic            busy_q;
   logic [2:0]      retry_q;
   logic [TW-1:0]   timer_q;

   logic [NREQ-1:0] pick;
   logic [IW-1:0]   pick_id;
   logic            wait_fail;
   logic            retry_ok;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req     (bus.req),
      .ptr     (ptr_q),
      .pick    (pick),
      .pick_id (pick_id)
   );

   // An attempt fails on error (even with done) or on the last WAIT cycle
   // without done; a failed attempt is retried while retries remain.
   assign wait_fail = bus.eng_error || (!bus.eng_done && (timer_q == TW'(TIMEOUT - 1)));
   assign retry_ok  = (retry_q < 3'(MAX_RETRY));

   // Scheduler FSM; every output is a register set on entry to its state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= IW'(NREQ - 1);
         grant_q    <= '0;
         grant_id_q <= '0;
         ack_q      <= '0;
         nack_q     <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         retry_q    <= '0;
         timer_q    <= '0;
      end else begin
         start_q <= 1'b0;
         ack_q   <= '0;
         nack_q  <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (|bus.req) begin
                  grant_q    <= pick;
                  grant_id_q <= pick_id;
                  retry_q    <= '0;
                  start_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer_q <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               timer_q <= timer_q + 1'b1;
               if (wait_fail) begin
                  if (retry_ok) begin
                     retry_q <= retry_q + 3'd1;
                     state_q <= S_RETRY;
                  end else begin
                     nack_q  <= grant_q;
                     state_q <= S_NACK;
                  end
               end else if (bus.eng_done) begin
                  ack_q   <= grant_q;
                  state_q <= S_ACK;
               end
            end
            S_RETRY: begin
               start_q <= 1'b1;
               state_q <= S_ISSUE;
            end
            S_ACK, S_NACK: begin
               ptr_q      <= grant_id_q;
               grant_q    <= '0;
               grant_id_q <= '0;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.eng_start = start_q;
   assign bus.grant     = grant_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.ack       = ack_q;
   assign bus.nack      = nack_q;
   assign bus.busy      = busy_q;
   assign bus.retry_cnt = retry_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_job_scheduler.sv
// Bench for job_scheduler: a table of whole jobs plus hand-written corner
// sequences; ack/nack outcomes are checked against an expected queue.
module tb_job_scheduler;
   import sched_pkg::*;

   localparam int NREQ = 4;
   localparam int TOUT = 8;
   localparam int MRET = 2;
   localparam int NV   = 11;

   // attempt codes (2 bits each, attempt 0 in the low bits):
   // 0 done, 1 error, 2 silent (timeout), 3 done+error together
   typedef struct {
      logic [3:0] req;
      logic [5:0] codes;
      int         dly;
      logic [3:0] grant;
      logic [1:0] gid;
      logic       ok;
      logic [2:0] retry;
   } vec_t;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   sched_state_t state;
   int           total = 0;
   int           bad   = 0;
   logic [10:0]  exp_q[$];
   logic [10:0]  e;
   vec_t         vecs[NV];
   int           lat;

   job_scheduler_if #(.NREQ(NREQ)) bus ();

   job_scheduler #(.NREQ(NREQ), .TIMEOUT(TOUT), .MAX_RETRY(MRET)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.master),
      .state_o (state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // scoreboard: every ack/nack pulse pops one expected outcome
   always @(negedge clk) begin
      if (reset && (bus.ack != 4'b0 || bus.nack != 4'b0)) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", 32'({bus.ack, bus.nack}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_ack",   32'(bus.ack),       32'(e[10:7]));
            chk("sb_nack",  32'(bus.nack),      32'(e[6:3]));
            chk("sb_retry", 32'(bus.retry_cnt), 32'(e[2:0]));
         end
      end
   end

   // driver: wait (bounded) for an eng_start pulse, return cycles taken
   task automatic wait_start(output int l);
      l = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus.eng_start) begin
            l = i;
            break;
         end
      end
      chk("start_seen", 32'(bus.eng_start), 32'd1);
   endtask

   // driver: play the engine for one attempt, starting at the ISSUE cycle
   task automatic run_attempt(input logic [1:0] code, input int dly, input int a);
      int           cnt;
      sched_state_t exp_s;
      if (code == 2'd2) begin
         cnt = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state != S_WAIT) break;
            cnt++;
         end
         chk("wait_len", 32'(cnt), 32'(TOUT));
      end else begin
         repeat (dly) @(negedge clk);
         bus.eng_done  = (code == 2'd0) || (code == 2'd3);
         bus.eng_error = (code == 2'd1) || (code == 2'd3);
         @(negedge clk);
         bus.eng_done  = 1'b0;
         bus.eng_error = 1'b0;
      end
      if (code == 2'd0)   exp_s = S_ACK;
      else if (a < MRET)  exp_s = S_RETRY;
      else                exp_s = S_NACK;
      chk("post_state", 32'(state), 32'(exp_s));
   endtask

   // driver: one complete job from the table
   task automatic run_job(input vec_t v, input int exp_lat, input logic [3:0] next_req);
      int l;
      exp_q.push_back({v.ok ? v.grant : 4'b0, v.ok ? 4'b0 : v.grant, v.retry});
      wait_start(l);
      chk("req_to_start", 32'(l), 32'(exp_lat));
      chk("grant",        32'(bus.grant),    32'(v.grant));
      chk("grant_id",     32'(bus.grant_id), 32'(v.gid));
      chk("busy_on",      32'(bus.busy),     32'd1);
      for (int a = 0; a <= MRET; a++) begin
         run_attempt(v.codes[2*a +: 2], v.dly, a);
         if (state != S_RETRY) break;
         chk("retry_cnt",   32'(bus.retry_cnt), 32'(a + 1));
         chk("retry_grant", 32'(bus.grant),     32'(v.grant));
         chk("retry_nostart", 32'(bus.eng_start), 32'd0);
         wait_start(l);
         chk("retry_gap", 32'(l), 32'd1);
      end
      bus.req = next_req;
   endtask

   initial begin
      bus.req       = '0;
      bus.eng_done  = 1'b0;
      bus.eng_error = 1'b0;

      //               req      codes      dly grant    gid  ok    retry
      vecs[0]  = '{4'b0001, 6'b000000, 3, 4'b0001, 2'd0, 1'b1, 3'd0};
      vecs[1]  = '{4'b1011, 6'b000000, 1, 4'b0010, 2'd1, 1'b1, 3'd0};
      vecs[2]  = '{4'b1011, 6'b000000, 2, 4'b1000, 2'd3, 1'b1, 3'd0};
      vecs[3]  = '{4'b1011, 6'b000000, 1, 4'b0001, 2'd0, 1'b1, 3'd0};
      vecs[4]  = '{4'b1011, 6'b000000, 4, 4'b0010, 2'd1, 1'b1, 3'd0};
      vecs[5]  = '{4'b1011, 6'b000000, 1, 4'b1000, 2'd3, 1'b1, 3'd0};
      vecs[6]  = '{4'b1011, 6'b000000, 2, 4'b0001, 2'd0, 1'b1, 3'd0};
      vecs[7]  = '{4'b0100, 6'b000001, 2, 4'b0100, 2'd2, 1'b1, 3'd1};
      vecs[8]  = '{4'b0001, 6'b101010, 1, 4'b0001, 2'd0, 1'b0, 3'd2};
      vecs[9]  = '{4'b1000, 6'b000011, 1, 4'b1000, 2'd3, 1'b1, 3'd1};
      vecs[10] = '{4'b0010, 6'b010101, 1, 4'b0010, 2'd1, 1'b0, 3'd2};

      // reset state
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state",     32'(state),         32'(S_IDLE));
      chk("rst_grant",     32'(bus.grant),     32'd0);
      chk("rst_grant_id",  32'(bus.grant_id),  32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_start",     32'(bus.eng_start), 32'd0);
      chk("rst_acknack",   32'({bus.ack, bus.nack}), 32'd0);
      chk("rst_retry",     32'(bus.retry_cnt), 32'd0);
      reset = 1'b1;

      // table of whole jobs; req for the next job is applied at the ack/nack
      @(negedge clk);
      bus.req = vecs[0].req;
      for (int i = 0; i < NV; i++) begin
         run_job(vecs[i], (i == 0) ? 1 : 2, (i + 1 < NV) ? vecs[i+1].req : 4'b0);
      end

      // engine pulses in IDLE are ignored
      @(negedge clk);
      chk("idle_state", 32'(state), 32'(S_IDLE));
      bus.eng_done  = 1'b1;
      bus.eng_error = 1'b1;
      @(negedge clk);
      bus.eng_done  = 1'b0;
      bus.eng_error = 1'b0;
      chk("idle_done_state", 32'(state), 32'(S_IDLE));
      chk("idle_done_ack",   32'({bus.ack, bus.nack}), 32'd0);
      chk("idle_done_busy",  32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("idle_done_later", 32'({bus.ack, bus.nack, bus.eng_start}), 32'd0);

      // single job with exact cycle timing (done 3 cycles after start)
      bus.req = 4'b0001;
      exp_q.push_back({4'b0001, 4'b0000, 3'd0});
      @(negedge clk);
      chk("sj_start", 32'(bus.eng_start), 32'd1);
      chk("sj_grant", 32'(bus.grant),     32'h1);
      chk("sj_busy",  32'(bus.busy),      32'd1);
      @(negedge clk);
      chk("sj_start_pulse", 32'(bus.eng_start), 32'd0);
      chk("sj_wait",        32'(state),         32'(S_WAIT));
      @(negedge clk);
      @(negedge clk);
      bus.eng_done = 1'b1;
      @(negedge clk);
      bus.eng_done = 1'b0;
      bus.req      = 4'b0000;
      chk("sj_ack",  32'(bus.ack),  32'h1);
      chk("sj_nack", 32'(bus.nack), 32'd0);
      @(negedge clk);
      chk("sj_busy_off",  32'(bus.busy),  32'd0);
      chk("sj_grant_off", 32'(bus.grant), 32'd0);
      chk("sj_ack_off",   32'(bus.ack),   32'd0);

      // reset mid-WAIT: outputs clear at once, ptr returns to NREQ-1
      bus.req = 4'b0100;
      @(negedge clk);
      @(negedge clk);
      chk("rm_wait", 32'(state), 32'(S_WAIT));
      #2 reset = 1'b0;
      #1;
      chk("rm_state", 32'(state), 32'(S_IDLE));
      chk("rm_outs",  32'({bus.grant, bus.grant_id, bus.busy, bus.eng_start, bus.retry_cnt}), 32'd0);
      chk("rm_acknack", 32'({bus.ack, bus.nack}), 32'd0);
      @(negedge clk);
      reset   = 1'b1;
      bus.req = 4'b0011;
      exp_q.push_back({4'b0001, 4'b0000, 3'd0});
      wait_start(lat);
      chk("rm_lat",      32'(lat),          32'd1);
      chk("rm_grant",    32'(bus.grant),    32'h1);
      chk("rm_grant_id", 32'(bus.grant_id), 32'd0);
      run_attempt(2'd0, 1, 0);
      bus.req = 4'b0000;
      @(negedge clk);
      chk("rm_busy_off", 32'(bus.busy), 32'd0);

      @(negedge clk);
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
